// File: rtl/vga_timing_gen.sv
// Raster timing generator: free-running h/v/linear counters with a registered
// decode of sync, blank and position. Outputs lag the counters by one enabled clock.
module vga_timing_gen #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic H_POL    = 1'b0,
    parameter logic V_POL    = 1'b0
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_en,
    output logic        o_hsync,
    output logic        o_vsync,
    output logic        o_blank,
    output logic [9:0]  o_pos_x,
    output logic [9:0]  o_pos_y,
    output logic [18:0] o_pixel_pos,
    output logic        o_line_start,
    output logic        o_frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [9:0]  h_cnt;
    logic [9:0]  v_cnt;
    logic [18:0] lin_cnt;

    logic h_wrap;
    logic v_wrap;
    logic hs_on;
    logic vs_on;

    assign h_wrap = (h_cnt == H_LAST);
    assign v_wrap = (v_cnt == V_LAST);
    assign hs_on  = (h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST);
    assign vs_on  = (v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST);

    // The linear index is stepped alongside h/v so no multiplier is needed.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            h_cnt   <= '0;
            v_cnt   <= '0;
            lin_cnt <= '0;
        end else if (i_en) begin
            // NOTE: non-blocking here so every decode below sees the pre-update counts.
            h_cnt   <= h_wrap ? '0 : h_cnt + 10'd1;
            lin_cnt <= (h_wrap && v_wrap) ? '0 : lin_cnt + 19'd1;
            if (h_wrap) begin
                v_cnt <= v_wrap ? '0 : v_cnt + 10'd1;
            end
        end
    end

    // vsync follows v_cnt, which only moves on an h wrap, so it is line-aligned.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_hsync       <= ~H_POL;
            o_vsync       <= ~V_POL;
            o_blank       <= 1'b1;
            o_pos_x       <= '0;
            o_pos_y       <= '0;
            o_pixel_pos   <= '0;
            o_line_start  <= 1'b0;
            o_frame_start <= 1'b0;
        end else if (i_en) begin
            o_hsync       <= hs_on ? H_POL : ~H_POL;
            o_vsync       <= vs_on ? V_POL : ~V_POL;
            o_blank       <= (h_cnt >= H_VIS) || (v_cnt >= V_VIS);
            o_pos_x       <= h_cnt;
            o_pos_y       <= v_cnt;
            o_pixel_pos   <= lin_cnt;
            o_line_start  <= (h_cnt == '0);
            o_frame_start <= (h_cnt == '0) && (v_cnt == '0);
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three parameter sets checked every cycle against a
// pixel-index model, plus literal expectations at the key raster positions.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic en  = 1'b1;
    bit   run = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    // Instance 0: defaults. Instance 1: tiny 8x6 frame, positive syncs.
    // Instance 2: default line, 15-line frame (vsync on lines 10..11).
    logic        hs0, vs0, bl0, ls0, fs0;
    logic [9:0]  x0, y0;
    logic [18:0] p0;
    logic        hs1, vs1, bl1, ls1, fs1;
    logic [9:0]  x1, y1;
    logic [18:0] p1;
    logic        hs2, vs2, bl2, ls2, fs2;
    logic [9:0]  x2, y2;
    logic [18:0] p2;

    vga_timing_gen u_def (
        .i_clk(clk), .i_rst(rst), .i_en(en),
        .o_hsync(hs0), .o_vsync(vs0), .o_blank(bl0),
        .o_pos_x(x0), .o_pos_y(y0), .o_pixel_pos(p0),
        .o_line_start(ls0), .o_frame_start(fs0)
    );

    vga_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .H_POL(1'b1), .V_POL(1'b1)
    ) u_small (
        .i_clk(clk), .i_rst(rst), .i_en(en),
        .o_hsync(hs1), .o_vsync(vs1), .o_blank(bl1),
        .o_pos_x(x1), .o_pos_y(y1), .o_pixel_pos(p1),
        .o_line_start(ls1), .o_frame_start(fs1)
    );

    vga_timing_gen #(
        .V_ACTIVE(8), .V_FP(2), .V_SYNC(2), .V_BP(3)
    ) u_mid (
        .i_clk(clk), .i_rst(rst), .i_en(en),
        .o_hsync(hs2), .o_vsync(vs2), .o_blank(bl2),
        .o_pos_x(x2), .o_pos_y(y2), .o_pixel_pos(p2),
        .o_line_start(ls2), .o_frame_start(fs2)
    );

    logic [43:0] act [3];
    assign act[0] = {hs0, vs0, bl0, ls0, fs0, x0, y0, p0};
    assign act[1] = {hs1, vs1, bl1, ls1, fs1, x1, y1, p1};
    assign act[2] = {hs2, vs2, bl2, ls2, fs2, x2, y2, p2};

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, actual, expected);
        end
    endtask

    // Reference: each instance shows one linear pixel index; everything else is
    // derived from that index with division/modulo and the line/frame layout.
    function automatic logic [43:0] model_out(input int i, input bit have, input int p);
        int  ha, hfp, hs, hbp, va, vfp, vs, vbp, ht, x, y;
        bit  hp, vp, h_on, v_on, hsync, vsync, blank;
        case (i)
            1:       begin ha = 4;   hfp = 1;  hs = 2;  hbp = 1;  va = 3;   vfp = 1;  vs = 1; vbp = 1;  hp = 1; vp = 1; end
            2:       begin ha = 640; hfp = 16; hs = 96; hbp = 48; va = 8;   vfp = 2;  vs = 2; vbp = 3;  hp = 0; vp = 0; end
            default: begin ha = 640; hfp = 16; hs = 96; hbp = 48; va = 480; vfp = 10; vs = 2; vbp = 33; hp = 0; vp = 0; end
        endcase
        if (!have) return {~hp, ~vp, 1'b1, 1'b0, 1'b0, 10'd0, 10'd0, 19'd0};
        ht    = ha + hfp + hs + hbp;
        x     = p % ht;
        y     = p / ht;
        h_on  = (x >= ha + hfp) && (x < ha + hfp + hs);
        v_on  = (y >= va + vfp) && (y < va + vfp + vs);
        hsync = h_on ? hp : ~hp;
        vsync = v_on ? vp : ~vp;
        blank = (x >= ha) || (y >= va);
        return {hsync, vsync, blank, (x == 0), (p == 0), 10'(x), 10'(y), 19'(p)};
    endfunction

    int tot [3] = '{420000, 48, 12000};
    int m_cur [3];
    int m_nxt [3];
    bit m_have;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_have <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                m_cur[i] <= 0;
                m_nxt[i] <= 0;
            end
        end else if (en) begin
            m_have <= 1'b1;
            for (int i = 0; i < 3; i++) begin
                m_cur[i] <= m_nxt[i];
                m_nxt[i] <= (m_nxt[i] + 1) % tot[i];
            end
        end
    end

    always @(negedge clk) begin
        if (run) begin
            check("model_def",   act[0], model_out(0, m_have, m_cur[0]));
            check("model_small", act[1], model_out(1, m_have, m_cur[1]));
            check("model_mid",   act[2], model_out(2, m_have, m_cur[2]));
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_def_x(input int target, input string name);
        bit found = 1'b0;
        for (int k = 0; k < 1000; k++) begin
            if (x0 == 10'(target)) begin
                found = 1'b1;
                break;
            end
            step(1);
        end
        check(name, 64'(found), 64'd1);
    endtask

    initial begin
        #2 rst = 1'b1;
        run = 1'b1;
        #1;
        check("rst_def",   act[0], {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 10'd0, 10'd0, 19'd0});
        check("rst_small", act[1], {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 10'd0, 10'd0, 19'd0});
        @(negedge clk);
        rst = 1'b0;

        step(1);      // edge 1
        check("e1_pos",    {x0, y0, p0}, {10'd0, 10'd0, 19'd0});
        check("e1_flags",  {bl0, fs0, ls0, hs0, vs0}, 5'b01111);
        step(4);      // edge 5
        check("small_x4_hs", {x1, hs1}, {10'd4, 1'b0});
        step(1);      // edge 6
        check("small_x5_hs", {x1, hs1}, {10'd5, 1'b1});
        step(2);      // edge 8
        check("small_x7_hs", {x1, hs1}, {10'd7, 1'b0});
        step(24);     // edge 32
        check("small_y3_vs", {y1, vs1}, {10'd3, 1'b0});
        step(1);      // edge 33
        check("small_y4_vs", {y1, vs1}, {10'd4, 1'b1});
        step(16);     // edge 49
        check("small_wrap", {p1, fs1}, {19'd0, 1'b1});
        step(591);    // edge 640
        check("e640", {x0, bl0}, {10'd639, 1'b0});
        step(1);      // edge 641
        check("e641", {x0, bl0}, {10'd640, 1'b1});
        step(15);     // edge 656
        check("e656_hs", {x0, hs0}, {10'd655, 1'b1});
        step(1);      // edge 657
        check("e657_hs", {x0, hs0}, {10'd656, 1'b0});
        step(95);     // edge 752
        check("e752_hs", {x0, hs0}, {10'd751, 1'b0});
        step(1);      // edge 753
        check("e753_hs", {x0, hs0}, {10'd752, 1'b1});
        step(48);     // edge 801
        check("e801_line", {x0, y0, ls0, p0}, {10'd0, 10'd1, 1'b1, 19'd800});
        step(7199);   // edge 8000
        check("mid_vs_before", {p2, vs2}, {19'd7999, 1'b1});
        step(1);      // edge 8001
        check("mid_vs_first", {p2, y2, vs2}, {19'd8000, 10'd10, 1'b0});
        step(1599);   // edge 9600
        check("mid_vs_last", {p2, vs2}, {19'd9599, 1'b0});
        step(1);      // edge 9601
        check("mid_vs_after", {p2, vs2}, {19'd9600, 1'b1});
        step(2399);   // edge 12000
        check("mid_last_px", {p2, x2, y2}, {19'd11999, 10'd799, 10'd14});
        step(1);      // edge 12001
        check("mid_wrap", {p2, fs2, ls2}, {19'd0, 1'b1, 1'b1});
        check("def_e12001", {x0, y0, p0, fs0}, {10'd0, 10'd15, 19'd12000, 1'b0});

        wait_def_x(100, "reach_x100");
        en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step(1);
            check("stall_hold", {x0, ls0}, {10'd100, 1'b0});
        end
        en = 1'b1;
        step(1);
        check("stall_resume", x0, 10'd101);

        repeat (15000) begin
            en = ($urandom_range(0, 7) != 0);
            step(1);
        end
        en = 1'b1;

        wait_def_x(300, "reach_x300");
        #2 rst = 1'b1;
        #1;
        check("async_rst_def",   act[0], {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 10'd0, 10'd0, 19'd0});
        check("async_rst_small", act[1], {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 10'd0, 10'd0, 19'd0});
        check("async_rst_mid",   act[2], {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 10'd0, 10'd0, 19'd0});
        @(negedge clk);
        rst = 1'b0;
        step(1);
        check("restart_e1", {x0, y0, p0, fs0, ls0, bl0}, {10'd0, 10'd0, 19'd0, 1'b1, 1'b1, 1'b0});
        step(1);
        check("restart_e2", {x0, p0, fs0}, {10'd1, 19'd1, 1'b0});

        repeat (2000) begin
            en = ($urandom_range(0, 3) != 0);
            step(1);
        end

        run = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
